// File: rtl/udp_tx_pkt_arbiter.sv
// udp_tx_pkt_arbiter
// Packet-granular round-robin arbiter. It shares one 512-bit EthernetTx fragment
// input among NUM_SRC requesters. A grant is held from the first beat of a packet
// until its last beat is accepted, so packets never interleave. The m_* outputs
// come from a single output register and can drive io_dataIn_* directly.
// Optional feature: define ARB_PKT_CNT_EN to add per-source 32-bit packet
// counters on the pkt_cnt output.
module udp_tx_pkt_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 512,
  parameter int KEEP_W  = 64,
  parameter int BN_W    = 16,
  parameter int GID_W   = 1
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [NUM_SRC-1:0]        s_valid,
  output logic [NUM_SRC-1:0]        s_ready,
  input  logic [NUM_SRC-1:0]        s_last,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC*BN_W-1:0]   s_byteNum,
  input  logic [NUM_SRC*KEEP_W-1:0] s_tkeep,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic [DATA_W-1:0]         m_data,
  output logic [BN_W-1:0]           m_byteNum,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [NUM_SRC*32-1:0]     pkt_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_e;

  state_e             state_q;
  logic [GID_W-1:0]   grant_q;
  logic [GID_W-1:0]   last_grant_q;
  logic               busy_q;

  logic               m_valid_q;
  logic               m_last_q;
  logic [DATA_W-1:0]  m_data_q;
  logic [BN_W-1:0]    m_byteNum_q;
  logic [KEEP_W-1:0]  m_tkeep_q;

  logic               sel_valid_s;
  logic               sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [BN_W-1:0]    sel_byteNum_s;
  logic [KEEP_W-1:0]  sel_tkeep_s;

  logic               out_free_s;
  logic               accept_s;
  logic               arb_found_s;
  logic [GID_W-1:0]   arb_idx_s;
  logic [GID_W:0]     cand_s;

  // The output register can take a new beat when it is empty or being drained now.
  assign out_free_s = ~m_valid_q | m_ready;
  assign accept_s   = (state_q == ST_PASS) & sel_valid_s & out_free_s;

  // Mux the granted source's beat; indices >= NUM_SRC never match a grant.
  always_comb begin
    sel_valid_s   = 1'b0;
    sel_last_s    = 1'b0;
    sel_data_s    = '0;
    sel_byteNum_s = '0;
    sel_tkeep_s   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (GID_W'(i) == grant_q) begin
        sel_valid_s   = s_valid[i];
        sel_last_s    = s_last[i];
        sel_data_s    = s_data[i*DATA_W +: DATA_W];
        sel_byteNum_s = s_byteNum[i*BN_W +: BN_W];
        sel_tkeep_s   = s_tkeep[i*KEEP_W +: KEEP_W];
      end else begin
        sel_valid_s   = sel_valid_s;
      end
    end
  end

  // Only the granted source sees ready, and only while passing a packet.
  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((state_q == ST_PASS) && (GID_W'(i) == grant_q)) begin
        s_ready[i] = out_free_s;
      end else begin
        s_ready[i] = 1'b0;
      end
    end
  end

  // Round-robin search starting just after the last source that finished a packet.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand_s = {1'b0, last_grant_q} + (GID_W+1)'(k);
      if (cand_s >= (GID_W+1)'(NUM_SRC)) begin
        cand_s = cand_s - (GID_W+1)'(NUM_SRC);
      end else begin
        cand_s = cand_s;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!arb_found_s && s_valid[i] && (GID_W'(i) == cand_s[GID_W-1:0])) begin
          arb_found_s = 1'b1;
          arb_idx_s   = GID_W'(i);
        end else begin
          arb_found_s = arb_found_s;
        end
      end
    end
  end

  // Packet-level FSM: grant in IDLE, hold the grant in PASS until the last beat is accepted.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GID_W'(NUM_SRC - 1);
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found_s) begin
            grant_q <= arb_idx_s;
            state_q <= ST_PASS;
            busy_q  <= 1'b1;
          end
        end
        ST_PASS: begin
          if (accept_s && sel_last_s) begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on accept, empty after a drain, otherwise hold everything.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      m_byteNum_q <= '0;
      m_tkeep_q   <= '0;
    end else if (accept_s) begin
      m_valid_q   <= 1'b1;
      m_last_q    <= sel_last_s;
      m_data_q    <= sel_data_s;
      m_byteNum_q <= sel_byteNum_s;
      m_tkeep_q   <= sel_tkeep_s;
    end else if (m_valid_q && m_ready) begin
      m_valid_q   <= 1'b0;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_data    = m_data_q;
  assign m_byteNum = m_byteNum_q;
  assign m_tkeep   = m_tkeep_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

`ifdef ARB_PKT_CNT_EN
  logic [NUM_SRC*32-1:0] pkt_cnt_q;

  // Count completed packets per source; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept_s && sel_last_s && (GID_W'(i) == grant_q)) begin
          pkt_cnt_q[i*32 +: 32] <= pkt_cnt_q[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule
